mem_amo_unit: RTL

//  Memory-side sequencer for EX-stage load/store/LR/SC/AMO ops; counterpart of the ALU's

---
 rtl/mem_amo_unit.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_amo_unit.sv
// Memory-side sequencer for EX-stage load/store/LR/SC/AMO operations.
// Drives a req/ack data bus, holds the LR/SC reservation and produces rd results.
//
//  state | meaning
//  IDLE  | ready for a new op
//  RD    | bus read outstanding (load, LR, AMO old value)
//  CALC  | one cycle for the ALU to combine old value with operand
//  WR    | bus write outstanding (store, SC, AMO write-back)
//  DONE  | one-cycle completion pulse, rd_data/err valid
module mem_amo_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [3:0]        req_size,
  input  logic              req_unsign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic [XLEN-1:0]   alu_mem_data,
  input  logic [XLEN-1:0]   alu_result,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_size,
  output logic [XLEN-1:0]   bus_wdata,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  input  logic              bus_err,
  output logic              done,
  output logic [XLEN-1:0]   rd_data,
  output logic              err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_WR   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_LR    = 3'b010;
  localparam logic [2:0] OP_SC    = 3'b011;
  localparam logic [2:0] OP_AMO   = 3'b100;

  logic [2:0]        state;
  logic [2:0]        op_q;
  logic [3:0]        size_q;
  logic              unsign_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   old_val;
  logic [XLEN-1:0]   rd_data_q;
  logic              err_q;
  logic              res_valid;
  logic [ADDR_W-4:0] res_addr;

  logic [2:0]        req_op_eff;
  logic              misaligned;
  logic              sc_hit;
  logic              wr_res_hit;
  logic              bus_active;
  logic [XLEN-1:0]   rdata_ext;

  // Byte-lane mask for the access size; anything not B/H/W is treated as a doubleword.
  function automatic logic [XLEN-1:0] size_mask(input logic [3:0] sz);
    logic [XLEN-1:0] m;
    m = '1;
    if (sz[0])      m = XLEN'(8'hff);
    else if (sz[1]) m = XLEN'(16'hffff);
    else if (sz[2]) m = XLEN'(32'hffff_ffff);
    return m;
  endfunction

  // Right-aligned read data extended to XLEN according to size and signedness.
  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                             input logic [3:0] sz,
                                             input logic uns);
    logic [XLEN-1:0] r;
    r = d;
    if (sz[0])      r = uns ? XLEN'(d[7:0])  : {{(XLEN-8){d[7]}},   d[7:0]};
    else if (sz[1]) r = uns ? XLEN'(d[15:0]) : {{(XLEN-16){d[15]}}, d[15:0]};
    else if (sz[2]) r = uns ? XLEN'(d[31:0]) : {{(XLEN-32){d[31]}}, d[31:0]};
    return r;
  endfunction

  // Request decode: unknown opcodes behave as loads; alignment check on the raw address.
  always_comb begin
    req_op_eff = (req_op > OP_AMO) ? OP_LOAD : req_op;
    misaligned = (req_size[1] & req_addr[0]) |
                 (req_size[2] & (|req_addr[1:0])) |
                 (req_size[3] & (|req_addr[2:0]));
    sc_hit     = res_valid && (res_addr == req_addr[ADDR_W-1:3]);
    wr_res_hit = res_valid && (res_addr == addr_q[ADDR_W-1:3]);
    bus_active = (state == ST_RD) || (state == ST_WR);
    // AMO old values are always sign-extended so the ALU sees a signed operand.
    rdata_ext  = extend(bus_rdata, size_q, unsign_q && (op_q != OP_AMO));
  end

  // Sequencer, operand latches, reservation and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= OP_LOAD;
      size_q    <= '0;
      unsign_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      old_val   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      res_valid <= 1'b0;
      res_addr  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q     <= req_op_eff;
            size_q   <= req_size;
            unsign_q <= req_unsign;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata & size_mask(req_size);
            if (req_op_eff == OP_SC) res_valid <= 1'b0;
            if (misaligned) begin
              state     <= ST_DONE;
              rd_data_q <= '0;
              err_q     <= 1'b1;
            end else begin
              case (req_op_eff)
                OP_STORE: state <= ST_WR;
                OP_SC: begin
                  if (sc_hit) begin
                    state <= ST_WR;
                  end else begin
                    state     <= ST_DONE;
                    rd_data_q <= XLEN'(1);
                    err_q     <= 1'b0;
                  end
                end
                default: state <= ST_RD;
              endcase
            end
          end
        end
        ST_RD: begin
          if (bus_ack) begin
            if (bus_err) begin
              state     <= ST_DONE;
              rd_data_q <= '0;
              err_q     <= 1'b1;
              res_valid <= 1'b0;
            end else begin
              old_val <= rdata_ext;
              if (op_q == OP_AMO) begin
                state <= ST_CALC;
              end else begin
                state     <= ST_DONE;
                rd_data_q <= rdata_ext;
                err_q     <= 1'b0;
                if (op_q == OP_LR) begin
                  res_valid <= 1'b1;
                  res_addr  <= addr_q[ADDR_W-1:3];
                end
              end
            end
          end
        end
        ST_CALC: begin
          wdata_q <= alu_result & size_mask(size_q);
          state   <= ST_WR;
        end
        ST_WR: begin
          if (bus_ack) begin
            state     <= ST_DONE;
            err_q     <= bus_err;
            rd_data_q <= (op_q == OP_AMO && !bus_err) ? old_val : '0;
            if (bus_err || wr_res_hit) res_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output drive: bus fields are only non-zero while an access is outstanding.
  always_comb begin
    req_ready    = rst_n && (state == ST_IDLE);
    bus_req      = bus_active;
    bus_we       = (state == ST_WR);
    bus_addr     = bus_active ? addr_q : '0;
    bus_size     = bus_active ? size_q : '0;
    bus_wdata    = (state == ST_WR) ? wdata_q : '0;
    alu_mem_data = old_val;
    done         = (state == ST_DONE);
    rd_data      = rd_data_q;
    err          = err_q;
  end

endmodule
